// File: rtl/soi_event_tx.sv
// Change-driven SOI observer: timestamps value changes and forced snapshots,
// queues them in a show-ahead FIFO and streams them out over valid/ready.
module soi_event_tx #(
    parameter int WIDTH    = 8,
    parameter int TS_WIDTH = 16,
    parameter int DEPTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       soi,
    input  logic                   snap_req,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [WIDTH-1:0]       ev_value,
    output logic [TS_WIDTH-1:0]    ev_ts,
    output logic                   ev_snap,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = WIDTH + TS_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

    state_t              r_state, w_next;
    logic [TS_WIDTH-1:0] r_ts;
    logic [WIDTH-1:0]    r_prev;
    logic                w_cap, w_load_prev;

    logic [EW-1:0]       r_mem [DEPTH];
    logic [AW-1:0]       r_wptr, r_rptr, w_head_idx;
    logic [LW-1:0]       r_level;
    logic [7:0]          r_drop;
    logic                w_full, w_pop, w_push, w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ts    <= '0;
            r_prev  <= '0;
        end else begin
            r_state <= w_next;
            r_ts    <= r_ts + TS_WIDTH'(1);
            if (w_load_prev) r_prev <= soi;
        end
    end

    // ARM always takes a baseline so prev is never compared across IDLE gaps.
    always_comb begin
        w_next      = r_state;
        w_cap       = 1'b0;
        w_load_prev = 1'b0;
        case (r_state)
            S_IDLE: if (enable) w_next = S_ARM;
            S_ARM: begin
                if (!enable) begin
                    w_next = S_IDLE;
                end else begin
                    w_cap       = 1'b1;
                    w_load_prev = 1'b1;
                    w_next      = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    w_next = S_IDLE;
                end else begin
                    w_load_prev = 1'b1;
                    w_cap       = (soi != r_prev) || snap_req;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_full = (r_level == LW'(DEPTH));
    assign w_pop  = ev_valid && ev_ready;
    assign w_push = w_cap && (!w_full || w_pop);
    assign w_drop = w_cap && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {soi, r_ts, snap_req};
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

    // When empty, show the slot just popped so outputs hold their last value.
    assign w_head_idx = (r_level == '0) ? r_rptr - AW'(1) : r_rptr;
    assign {ev_value, ev_ts, ev_snap} = r_mem[w_head_idx];
    assign ev_valid = (r_level != '0);
    assign level    = r_level;
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_soi_event_tx.sv
// Scoreboard bench for soi_event_tx: expected events are queued as stimulus
// is driven and compared whenever the DUT hands an event to the collector.
module tb_soi_event_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  soi;
    logic        snap_req;
    logic        ev_valid;
    logic        ev_ready;
    logic [7:0]  ev_value;
    logic [15:0] ev_ts;
    logic        ev_snap;
    logic [3:0]  level;
    logic [7:0]  drop_cnt;

    logic [15:0] m_ts;
    logic [24:0] sb [$];
    int          n_chk = 0;
    int          n_pass = 0;

    soi_event_tx #(.WIDTH(8), .TS_WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .soi(soi),
        .snap_req(snap_req), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_value(ev_value), .ev_ts(ev_ts), .ev_snap(ev_snap),
        .level(level), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference timestamp: value the DUT will sample at the next rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_ts <= '0;
        else        m_ts <= m_ts + 16'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_event", 32'(sb.size()), 32'd1);
            end else begin
                logic [24:0] e;
                e = sb.pop_front();
                check("ev_value", 32'(ev_value), 32'(e[24:17]));
                check("ev_ts",    32'(ev_ts),    32'(e[16:1]));
                check("ev_snap",  32'(ev_snap),  32'(e[0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [7:0] v, input logic s, input logic exp);
        soi      = v;
        snap_req = s;
        if (exp) sb.push_back({v, m_ts, s});
        tick();
        snap_req = 1'b0;
    endtask

    task automatic drain();
        ev_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("drain_level", 32'(level), 32'd0);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; soi = 8'h00; snap_req = 1'b0; ev_ready = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(ev_valid), 0);
        check("rst_value", 32'(ev_value), 0);
        check("rst_ts",    32'(ev_ts),    0);
        check("rst_snap",  32'(ev_snap),  0);
        check("rst_level", 32'(level),    0);
        check("rst_drop",  32'(drop_cnt), 0);
        rst_n = 1'b1;

        // Baseline
        soi = 8'h5A; enable = 1'b1;
        tick();
        step(8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        check("base_level", 32'(level), 32'd1);
        check("base_valid", 32'(ev_valid), 32'd1);
        drain();

        // Change stream with repeat
        ev_ready = 1'b1;
        step(8'h01, 1'b0, 1'b1); check("cs_lvl", 32'(level <= 4'd1), 1);
        step(8'h01, 1'b0, 1'b0); check("cs_lvl", 32'(level <= 4'd1), 1);
        step(8'h02, 1'b0, 1'b1); check("cs_lvl", 32'(level <= 4'd1), 1);
        step(8'h03, 1'b0, 1'b1); check("cs_lvl", 32'(level <= 4'd1), 1);
        drain();

        // Snapshots
        step(8'h33, 1'b0, 1'b1);
        step(8'h33, 1'b0, 1'b0);
        step(8'h33, 1'b0, 1'b0);
        step(8'h33, 1'b1, 1'b1);
        step(8'h34, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(8'h34, 1'b0, 1'b0);
        drain();

        // Overflow, then push+pop at full
        ev_ready = 1'b0;
        for (int i = 0; i < 12; i++) step(8'h80 + 8'(i), 1'b0, i < 8);
        check("ovf_level", 32'(level), 32'd8);
        check("ovf_drop",  32'(drop_cnt), 32'd4);
        ev_ready = 1'b1;
        step(8'h90, 1'b0, 1'b1);
        check("full_pp_level", 32'(level), 32'd8);
        check("full_pp_drop",  32'(drop_cnt), 32'd4);
        drain();

        // Drop counter saturation
        ev_ready = 1'b0;
        for (int i = 0; i < 308; i++) step((i % 2) ? 8'h11 : 8'h10, 1'b0, i < 8);
        check("sat_drop", 32'(drop_cnt), 32'd255);
        drain();

        // Timestamp wrap
        ev_ready = 1'b1;
        for (int i = 0; i < 70000 && m_ts != 16'hFFFF; i++) tick();
        sb.push_back({8'hA0, 16'hFFFF, 1'b0});
        step(8'hA0, 1'b0, 1'b0);
        sb.push_back({8'hA1, 16'h0000, 1'b0});
        step(8'hA1, 1'b0, 1'b0);
        drain();

        // Enable deassert keeps queue, re-enable takes a fresh baseline
        ev_ready = 1'b0;
        step(8'hB1, 1'b0, 1'b1);
        step(8'hB2, 1'b0, 1'b1);
        step(8'hB3, 1'b0, 1'b1);
        enable = 1'b0;
        step(8'hC0, 1'b0, 1'b0);
        step(8'hC1, 1'b1, 1'b0);
        step(8'hC2, 1'b0, 1'b0);
        check("dis_level", 32'(level), 32'd3);
        drain();
        ev_ready = 1'b0;
        enable = 1'b1;
        tick();
        step(8'hC2, 1'b0, 1'b1);
        step(8'hD0, 1'b0, 1'b1);
        step(8'hD1, 1'b0, 1'b1);
        check("reen_level", 32'(level), 32'd3);

        // Asynchronous reset mid-drain
        ev_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(ev_valid), 0);
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_drop",  32'(drop_cnt), 0);
        sb.delete();
        tick(); tick();
        check("post_rst_value", 32'(ev_value), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
